// File: rtl/spi_count_reader.sv
// SPI mode-0 slave returning snapshotted encoder counts, a constant ID word and a transaction counter.
// Optional macro SPI_XACT_CNT_EN implements the transaction counter at address 0x03.
module spi_count_reader (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] count_left,
    input  logic [15:0] count_right,
    input  logic        spi_cs_n,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        spi_miso
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned BIT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_e;

    // Two synchroniser stages plus one history stage for edge detection.
    logic [2:0]        cs_sync_q,   cs_sync_d;
    logic [2:0]        sclk_sync_q, sclk_sync_d;
    logic [1:0]        mosi_sync_q, mosi_sync_d;

    state_e            state_q,     state_d;
    logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
    logic [ADDR_W-1:0] shift_in_q,  shift_in_d;
    logic [DATA_W-1:0] shift_out_q, shift_out_d;
    logic [DATA_W-1:0] snap_left_q, snap_left_d;
    logic [DATA_W-1:0] snap_right_q, snap_right_d;
    logic              miso_q,      miso_d;
`ifdef SPI_XACT_CNT_EN
    logic [DATA_W-1:0] xact_cnt_q,  xact_cnt_d;
`endif

    logic              cs_fall_c, cs_rise_c, sclk_rise_c, sclk_fall_c, mosi_c;
    logic [ADDR_W-1:0] addr_c;
    logic [DATA_W-1:0] rd_word_c;

    always_comb begin
        cs_sync_d   = {cs_sync_q[1:0], spi_cs_n};
        sclk_sync_d = {sclk_sync_q[1:0], spi_sclk};
        mosi_sync_d = {mosi_sync_q[0], spi_mosi};
    end

    assign cs_fall_c   =  cs_sync_q[2]   & ~cs_sync_q[1];
    assign cs_rise_c   = ~cs_sync_q[2]   &  cs_sync_q[1];
    assign sclk_rise_c = ~sclk_sync_q[2] &  sclk_sync_q[1];
    assign sclk_fall_c =  sclk_sync_q[2] & ~sclk_sync_q[1];
    assign mosi_c      =  mosi_sync_q[1];
    assign addr_c      = {shift_in_q[ADDR_W-2:0], mosi_c};

    // Read mux, evaluated on the address as completed by the current MOSI bit.
    always_comb begin
        rd_word_c = 16'hDEAD;
        case (addr_c)
            8'h00:   rd_word_c = snap_left_q;
            8'h01:   rd_word_c = snap_right_q;
            8'h02:   rd_word_c = 16'h5A01;
`ifdef SPI_XACT_CNT_EN
            8'h03:   rd_word_c = xact_cnt_q;
`else
            8'h03:   rd_word_c = 16'h0000;
`endif
            default: rd_word_c = 16'hDEAD;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_in_d   = shift_in_q;
        shift_out_d  = shift_out_q;
        snap_left_d  = snap_left_q;
        snap_right_d = snap_right_q;
        miso_d       = 1'b0;
`ifdef SPI_XACT_CNT_EN
        xact_cnt_d   = xact_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (cs_fall_c) begin
                    snap_left_d  = count_left;
                    snap_right_d = count_right;
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (cs_rise_c) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise_c) begin
                    shift_in_d = addr_c;
                    if (bit_cnt_q == BIT_W'(ADDR_W - 1)) begin
                        shift_out_d = rd_word_c;
                        bit_cnt_d   = '0;
                        state_d     = ST_DATA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (cs_rise_c) begin
                    state_d = ST_IDLE;
                end else if (sclk_rise_c) begin
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        state_d = ST_DONE;
`ifdef SPI_XACT_CNT_EN
                        xact_cnt_d = xact_cnt_q + DATA_W'(1);
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else if (sclk_fall_c && bit_cnt_q != '0) begin
                    // The falling edge right after the last address bit keeps bit 15 on the line.
                    shift_out_d = {shift_out_q[DATA_W-2:0], 1'b0};
                end
            end
            ST_DONE: begin
                if (cs_rise_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_DATA) begin
            miso_d = shift_out_d[DATA_W-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_q    <= 3'b111;
            sclk_sync_q  <= 3'b000;
            mosi_sync_q  <= 2'b00;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            shift_in_q   <= '0;
            shift_out_q  <= '0;
            snap_left_q  <= '0;
            snap_right_q <= '0;
            miso_q       <= 1'b0;
`ifdef SPI_XACT_CNT_EN
            xact_cnt_q   <= '0;
`endif
        end else begin
            cs_sync_q    <= cs_sync_d;
            sclk_sync_q  <= sclk_sync_d;
            mosi_sync_q  <= mosi_sync_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_in_q   <= shift_in_d;
            shift_out_q  <= shift_out_d;
            snap_left_q  <= snap_left_d;
            snap_right_q <= snap_right_d;
            miso_q       <= miso_d;
`ifdef SPI_XACT_CNT_EN
            xact_cnt_q   <= xact_cnt_d;
`endif
        end
    end

    assign spi_miso = miso_q;

endmodule
